hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer of the pipeline's LE (PC/IF_ID load enable) and S (CU_MUX bubble select) controls, plus operand-forwarding selects and the IF squash for taken branches.
- Keeps its own shadow of destination-register / RF_LE / L state for the EX, MEM and WB stages.
- Detects load-use hazards and drives a branch-flush FSM.
- Sits beside the control unit in ID; its outputs feed the fetch registers, CU_MUX and the EX-stage operand muxes.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF_ID is squashed after a taken branch. Legal range 1..7.
- CNT_W, 16, width of the saturating stall/flush event counter.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- RA_ID  input  5  source register A of the instruction in ID.
- RB_ID  input  5  source register B of the instruction in ID.
- RA_USE  input  1  instruction in ID reads RA.
- RB_USE  input  1  instruction in ID reads RB.
- RD_ID  input  5  destination register of the instruction in ID.
- RF_LE_ID  input  1  RF_LE from the control unit, before CU_MUX.
- L_ID  input  1  L (load) from the control unit, before CU_MUX.
- BR_TAKEN  input  1  branch resolved taken in EX.
- LE  output  1  load enable for PC_BACK, PC_FRONT and IF_ID.
- S  output  1  CU_MUX select: 1 = bubble (all control bits zero) into ID_EX.
- FLUSH_IF  output  1  IF_ID loads NOP (all zeros) this edge.
- FWD_A  output  2  operand A source: 00 RF, 01 EX result, 10 MEM result, 11 WB result.
- FWD_B  output  2  operand B source, same encoding as FWD_A.
- EVT_CNT  output  CNT_W  saturating count of stall plus flush cycles.

Behaviour:
Shadow pipeline:
- Three registers, EX/MEM/WB, each holding {RD[4:0], RF_LE, L}.
- Every Clk edge: WB<=MEM, MEM<=EX, and EX<=(S ? {0,0,0} : {RD_ID,RF_LE_ID,L_ID}).
- A stage "writes r" iff its RF_LE=1 and RD=r and r!=0. r0 never hazards and never forwards.

Load-use stall (combinational):
- Condition LU = EX.L & EX writes RA_ID & RA_USE, OR the same with RB.
- When LU=1: LE=0, S=1. The ID instruction is held and a bubble enters EX.
- The next cycle forwards from MEM (FWD=10). There is exactly one stall cycle per load-use.

Forwarding (combinational, per operand, only when the matching *_USE=1, else 00):
- EX writes r and EX.L=0 -> 01.
- Else MEM writes r -> 10.
- Else WB writes r -> 11.
- Else 00.
- EX with L=1 never forwards; LU covers that case.

Branch FSM, states RUN and FLUSH, with a 3-bit down counter CNT:
- RUN, BR_TAKEN=1: FLUSH_IF=1 that cycle. The ID instruction is the delay slot and proceeds. If FLUSH_CYCLES>1, go to FLUSH with CNT=FLUSH_CYCLES-1; else stay in RUN.
- FLUSH: FLUSH_IF=1 and CNT decrements each cycle. When CNT reaches 1, return to RUN on the next edge.
- BR_TAKEN while in FLUSH is ignored, because the EX instruction is already a squashed bubble.

Priority / simultaneous events:
- BR_TAKEN and LU in the same cycle: both act. LE=0 and S=1 hold the delay slot in ID, and FLUSH_IF=1 is still asserted.
- FLUSH_IF qualifies IF_ID loading only; it is never gated by LE.
- LE=0 holds the PC.

Event counter:
- EVT_CNT increments by 1 on any cycle where (LU | FLUSH_IF) = 1.
- It saturates at all ones and never wraps.

Reset (Rst=1, asynchronous):
- Shadow registers cleared; FSM=RUN; CNT=0; EVT_CNT=0.
- Outputs while Rst is high: LE=0, S=1, FLUSH_IF=0, FWD_A=FWD_B=00.
- Reset mid-flush abandons the flush.
- First edge after Rst deasserts: LE=1, S=0, unless LU holds.

Latency:
- LE, S and FWD_* are combinational from inputs plus the shadow registers: zero-cycle.
- Shadow state updates on each Clk edge.

Test Plan:
1. Reset mid-flush: FLUSH_CYCLES=3, BR_TAKEN pulse, then Rst after 1 cycle -> LE=0, S=1, FLUSH_IF=0 and EVT_CNT=0 immediately (async). After release, state=RUN, LE=1, S=0.
2. ALU chain: ID writes r5, next ID reads RA=5 with RA_USE=1 -> FWD_A=01. One cycle later, a reader with RB=5 -> FWD_B=10. LE=1 and S=0 throughout.
3. Load-use: load with RD=7, L_ID=1, followed by a reader with RA=7 -> one cycle with LE=0, S=1 and EVT_CNT increments by 1. The following cycle FWD_A=10 and LE=1.
4. r0 immunity: load with RD=0, then a reader with RA=0 -> no stall, FWD_A=00.
5. Taken branch, FLUSH_CYCLES=1: BR_TAKEN=1 for one cycle -> FLUSH_IF=1 for exactly one cycle, LE stays 1, the delay slot reaches EX. FLUSH_CYCLES=3 -> FLUSH_IF high for 3 consecutive cycles.
6. Simultaneous and saturation: BR_TAKEN together with LU -> LE=0, S=1, FLUSH_IF=1. With CNT_W=2, five hazard cycles -> EVT_CNT holds at 3.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller beside ID: shadows EX/MEM/WB destination state, raises
// load-use stalls, selects operand forwarding and squashes IF after taken branches.
module hazard_stall_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       RA_ID,
  input  logic [4:0]       RB_ID,
  input  logic             RA_USE,
  input  logic             RB_USE,
  input  logic [4:0]       RD_ID,
  input  logic             RF_LE_ID,
  input  logic             L_ID,
  input  logic             BR_TAKEN,
  output logic             LE,
  output logic             S,
  output logic             FLUSH_IF,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic [3:0]       o_dbg_state
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [2:0]       LP_CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam bit               LP_MULTI    = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_MAX      = '1;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic [4:0]       r_ex_rd,  r_mem_rd,  r_wb_rd;
  logic             r_ex_rfle, r_mem_rfle, r_wb_rfle;
  logic             r_ex_l,   r_mem_l,   r_wb_l;
  logic [0:0]       r_state;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_evt_cnt;

  logic w_lu;
  logic w_evt;
  logic w_ex_a, w_mem_a, w_wb_a;
  logic w_ex_b, w_mem_b, w_wb_b;

  function automatic logic stage_writes(input logic [4:0] rd, input logic rf_le,
                                        input logic [4:0] r);
    return rf_le && (rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic ex_w,
                                         input logic ex_l, input logic mem_w,
                                         input logic wb_w);
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_r) begin
      // A load in EX has no result yet; the load-use stall covers it.
      if (ex_w && !ex_l) sel = SEL_EX;
      else if (mem_w)    sel = SEL_MEM;
      else if (wb_w)     sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    w_ex_a  = stage_writes(r_ex_rd,  r_ex_rfle,  RA_ID);
    w_mem_a = stage_writes(r_mem_rd, r_mem_rfle, RA_ID);
    w_wb_a  = stage_writes(r_wb_rd,  r_wb_rfle,  RA_ID);
    w_ex_b  = stage_writes(r_ex_rd,  r_ex_rfle,  RB_ID);
    w_mem_b = stage_writes(r_mem_rd, r_mem_rfle, RB_ID);
    w_wb_b  = stage_writes(r_wb_rd,  r_wb_rfle,  RB_ID);
    w_lu    = r_ex_l && ((w_ex_a && RA_USE) || (w_ex_b && RB_USE));
  end

  always_comb begin
    LE       = 1'b0;
    S        = 1'b1;
    FLUSH_IF = 1'b0;
    FWD_A    = SEL_RF;
    FWD_B    = SEL_RF;
    if (!Rst) begin
      LE       = !w_lu;
      S        = w_lu;
      // FLUSH_IF is independent of LE: a stalled delay slot still squashes IF.
      FLUSH_IF = (r_state == ST_FLUSH) || BR_TAKEN;
      FWD_A    = fwd_sel(RA_USE, w_ex_a, r_ex_l, w_mem_a, w_wb_a);
      FWD_B    = fwd_sel(RB_USE, w_ex_b, r_ex_l, w_mem_b, w_wb_b);
    end
  end

  assign w_evt       = w_lu || FLUSH_IF;
  assign EVT_CNT     = r_evt_cnt;
  assign o_dbg_state = {r_state, r_cnt};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ex_rd    <= 5'd0;
      r_ex_rfle  <= 1'b0;
      r_ex_l     <= 1'b0;
      r_mem_rd   <= 5'd0;
      r_mem_rfle <= 1'b0;
      r_mem_l    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_rfle  <= 1'b0;
      r_wb_l     <= 1'b0;
    end else begin
      r_wb_rd    <= r_mem_rd;
      r_wb_rfle  <= r_mem_rfle;
      r_wb_l     <= r_mem_l;
      r_mem_rd   <= r_ex_rd;
      r_mem_rfle <= r_ex_rfle;
      r_mem_l    <= r_ex_l;
      if (S) begin
        r_ex_rd   <= 5'd0;
        r_ex_rfle <= 1'b0;
        r_ex_l    <= 1'b0;
      end else begin
        r_ex_rd   <= RD_ID;
        r_ex_rfle <= RF_LE_ID;
        r_ex_l    <= L_ID;
      end
    end
  end

  // RUN: a taken branch squashes IF this cycle; FLUSH covers the remaining cycles.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (BR_TAKEN && LP_MULTI) begin
            r_state <= ST_FLUSH;
            r_cnt   <= LP_CNT_INIT;
          end
        end
        ST_FLUSH: begin
          if (r_cnt <= 3'd1) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_evt_cnt <= '0;
    end else if (w_evt && (r_evt_cnt != LP_MAX)) begin
      r_evt_cnt <= r_evt_cnt + LP_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: three instances share stimulus
// (default, FLUSH_CYCLES=3, CNT_W=2) and each task checks its own scenario.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ra_id, rb_id, rd_id;
  logic       ra_use, rb_use, rf_le_id, l_id, br_taken;

  logic        le, s, flush_if;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] evt;
  logic [3:0]  dbg;

  logic        le_3, s_3, flush_if_3;
  logic [1:0]  fwd_a_3, fwd_b_3;
  logic [15:0] evt_3;
  logic [3:0]  dbg_3;

  logic        le_s, s_s, flush_if_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [1:0]  evt_s;
  logic [3:0]  dbg_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut (
    .Clk(clk), .Rst(rst), .RA_ID(ra_id), .RB_ID(rb_id), .RA_USE(ra_use), .RB_USE(rb_use),
    .RD_ID(rd_id), .RF_LE_ID(rf_le_id), .L_ID(l_id), .BR_TAKEN(br_taken),
    .LE(le), .S(s), .FLUSH_IF(flush_if), .FWD_A(fwd_a), .FWD_B(fwd_b),
    .EVT_CNT(evt), .o_dbg_state(dbg));

  hazard_stall_unit #(.FLUSH_CYCLES(3), .CNT_W(16)) u_f3 (
    .Clk(clk), .Rst(rst), .RA_ID(ra_id), .RB_ID(rb_id), .RA_USE(ra_use), .RB_USE(rb_use),
    .RD_ID(rd_id), .RF_LE_ID(rf_le_id), .L_ID(l_id), .BR_TAKEN(br_taken),
    .LE(le_3), .S(s_3), .FLUSH_IF(flush_if_3), .FWD_A(fwd_a_3), .FWD_B(fwd_b_3),
    .EVT_CNT(evt_3), .o_dbg_state(dbg_3));

  hazard_stall_unit #(.FLUSH_CYCLES(1), .CNT_W(2)) u_sat (
    .Clk(clk), .Rst(rst), .RA_ID(ra_id), .RB_ID(rb_id), .RA_USE(ra_use), .RB_USE(rb_use),
    .RD_ID(rd_id), .RF_LE_ID(rf_le_id), .L_ID(l_id), .BR_TAKEN(br_taken),
    .LE(le_s), .S(s_s), .FLUSH_IF(flush_if_s), .FWD_A(fwd_a_s), .FWD_B(fwd_b_s),
    .EVT_CNT(evt_s), .o_dbg_state(dbg_s));

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ra_id = 5'd0; rb_id = 5'd0; rd_id = 5'd0;
    ra_use = 1'b0; rb_use = 1'b0; rf_le_id = 1'b0; l_id = 1'b0; br_taken = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    ra_id = 5'd3; ra_use = 1'b1;
    rst = 1'b1;
    #3;
    total++; if (le !== 1'b0) begin bad++; $display("FAIL rst_le got=%0b exp=0", le); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL rst_s got=%0b exp=1", s); end
    total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0b exp=0", flush_if); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL rst_fwd_a got=%0b exp=00", fwd_a); end
    total++; if (evt !== 16'd0) begin bad++; $display("FAIL rst_evt got=%0d exp=0", evt); end
    rst = 1'b0;
    idle();
    step();
    total++; if (le !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL rel_le_s got=%0b%0b exp=10", le, s); end
    br_taken = 1'b1;
    #1;
    total++; if (flush_if_3 !== 1'b1) begin bad++; $display("FAIL mid_br_flush got=%0b exp=1", flush_if_3); end
    step();
    br_taken = 1'b0;
    #1;
    total++; if (dbg_3 !== 4'b1010) begin bad++; $display("FAIL mid_state got=%b exp=1010", dbg_3); end
    total++; if (flush_if_3 !== 1'b1) begin bad++; $display("FAIL mid_flush got=%0b exp=1", flush_if_3); end
    total++; if (evt_3 !== 16'd1) begin bad++; $display("FAIL mid_evt got=%0d exp=1", evt_3); end
    rst = 1'b1;
    #1;
    total++; if (flush_if_3 !== 1'b0) begin bad++; $display("FAIL async_flush got=%0b exp=0", flush_if_3); end
    total++; if (evt_3 !== 16'd0) begin bad++; $display("FAIL async_evt got=%0d exp=0", evt_3); end
    total++; if (le_3 !== 1'b0 || s_3 !== 1'b1) begin bad++; $display("FAIL async_le_s got=%0b%0b exp=01", le_3, s_3); end
    #1;
    rst = 1'b0;
    step();
    total++; if (dbg_3 !== 4'b0000) begin bad++; $display("FAIL post_state got=%b exp=0000", dbg_3); end
    total++; if (flush_if_3 !== 1'b0) begin bad++; $display("FAIL post_flush got=%0b exp=0", flush_if_3); end
    total++; if (le_3 !== 1'b1 || s_3 !== 1'b0) begin bad++; $display("FAIL post_le_s got=%0b%0b exp=10", le_3, s_3); end
  endtask

  task automatic test_alu_chain();
    do_reset();
    rd_id = 5'd5; rf_le_id = 1'b1;
    #1;
    total++; if (le !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL alu0_le_s got=%0b%0b exp=10", le, s); end
    step();
    idle(); ra_id = 5'd5; ra_use = 1'b1;
    #1;
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL alu_ex_fwd_a got=%b exp=01", fwd_a); end
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL alu_unused_fwd_b got=%b exp=00", fwd_b); end
    total++; if (le !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL alu1_le_s got=%0b%0b exp=10", le, s); end
    step();
    idle(); rb_id = 5'd5; rb_use = 1'b1; ra_id = 5'd5; rd_id = 5'd5; rf_le_id = 1'b1;
    #1;
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL alu_mem_fwd_b got=%b exp=10", fwd_b); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL alu_nouse_fwd_a got=%b exp=00", fwd_a); end
    step();
    idle(); ra_id = 5'd5; ra_use = 1'b1; rb_id = 5'd5; rb_use = 1'b1;
    #1;
    total++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin bad++; $display("FAIL alu_ex_over_wb got=%b%b exp=0101", fwd_a, fwd_b); end
    step();
    #1;
    total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL alu_mem2_fwd_a got=%b exp=10", fwd_a); end
    step();
    #1;
    total++; if (fwd_a !== 2'b11) begin bad++; $display("FAIL alu_wb_fwd_a got=%b exp=11", fwd_a); end
    total++; if (evt !== 16'd0) begin bad++; $display("FAIL alu_evt got=%0d exp=0", evt); end
  endtask

  task automatic test_load_use();
    do_reset();
    rd_id = 5'd7; rf_le_id = 1'b1; l_id = 1'b1;
    step();
    idle(); ra_id = 5'd7; ra_use = 1'b1;
    #1;
    total++; if (le !== 1'b0 || s !== 1'b1) begin bad++; $display("FAIL lu_le_s got=%0b%0b exp=01", le, s); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL lu_fwd_a got=%b exp=00", fwd_a); end
    step();
    #1;
    total++; if (evt !== 16'd1) begin bad++; $display("FAIL lu_evt got=%0d exp=1", evt); end
    total++; if (le !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL lu_after_le_s got=%0b%0b exp=10", le, s); end
    total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL lu_after_fwd_a got=%b exp=10", fwd_a); end
    step();
    #1;
    total++; if (evt !== 16'd1) begin bad++; $display("FAIL lu_one_evt got=%0d exp=1", evt); end
    idle(); rd_id = 5'd9; rf_le_id = 1'b1; l_id = 1'b1;
    step();
    idle(); rb_id = 5'd9; rb_use = 1'b0;
    #1;
    total++; if (le !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL lu_nouse_le_s got=%0b%0b exp=10", le, s); end
    rb_use = 1'b1;
    #1;
    total++; if (le !== 1'b0 || s !== 1'b1) begin bad++; $display("FAIL lu_rb_le_s got=%0b%0b exp=01", le, s); end
  endtask

  task automatic test_r0();
    do_reset();
    rd_id = 5'd0; rf_le_id = 1'b1; l_id = 1'b1;
    step();
    idle(); ra_id = 5'd0; ra_use = 1'b1; rb_id = 5'd0; rb_use = 1'b1;
    #1;
    total++; if (le !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL r0_le_s got=%0b%0b exp=10", le, s); end
    total++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL r0_fwd got=%b%b exp=0000", fwd_a, fwd_b); end
    step();
    total++; if (evt !== 16'd0) begin bad++; $display("FAIL r0_evt got=%0d exp=0", evt); end
  endtask

  task automatic test_branch();
    do_reset();
    br_taken = 1'b1; rd_id = 5'd3; rf_le_id = 1'b1;
    #1;
    total++; if (flush_if !== 1'b1 || flush_if_3 !== 1'b1) begin bad++; $display("FAIL br0_flush got=%0b%0b exp=11", flush_if, flush_if_3); end
    total++; if (le !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL br0_le_s got=%0b%0b exp=10", le, s); end
    step();
    idle(); ra_id = 5'd3; ra_use = 1'b1;
    #1;
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL br_slot_fwd got=%b exp=01", fwd_a); end
    total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL br1_flush_fc1 got=%0b exp=0", flush_if); end
    total++; if (flush_if_3 !== 1'b1) begin bad++; $display("FAIL br1_flush_fc3 got=%0b exp=1", flush_if_3); end
    step();
    idle(); br_taken = 1'b1;
    #1;
    total++; if (flush_if_3 !== 1'b1 || dbg_3 !== 4'b1001) begin bad++; $display("FAIL br2_fc3 got=%0b/%b exp=1/1001", flush_if_3, dbg_3); end
    step();
    idle();
    #1;
    total++; if (flush_if_3 !== 1'b0 || dbg_3 !== 4'b0000) begin bad++; $display("FAIL br3_fc3 got=%0b/%b exp=0/0000", flush_if_3, dbg_3); end
    total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL br3_fc1 got=%0b exp=0", flush_if); end
    total++; if (evt !== 16'd2 || evt_3 !== 16'd3) begin bad++; $display("FAIL br_evt got=%0d/%0d exp=2/3", evt, evt_3); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rd_id = 5'd4; rf_le_id = 1'b1; l_id = 1'b1;
    step();
    idle(); ra_id = 5'd4; ra_use = 1'b1; br_taken = 1'b1;
    #1;
    total++; if (le !== 1'b0 || s !== 1'b1 || flush_if !== 1'b1) begin bad++; $display("FAIL sim_ctl got=%0b%0b%0b exp=011", le, s, flush_if); end
    step();
    br_taken = 1'b0;
    #1;
    total++; if (evt !== 16'd1) begin bad++; $display("FAIL sim_evt got=%0d exp=1", evt); end
    total++; if (le !== 1'b1 || fwd_a !== 2'b10) begin bad++; $display("FAIL sim_after got=%0b/%b exp=1/10", le, fwd_a); end
  endtask

  task automatic test_saturation();
    do_reset();
    br_taken = 1'b1;
    step(); step();
    #1;
    total++; if (evt_s !== 2'd2) begin bad++; $display("FAIL sat2_evt got=%0d exp=2", evt_s); end
    step(); step(); step();
    br_taken = 1'b0;
    #1;
    total++; if (evt_s !== 2'd3) begin bad++; $display("FAIL sat_evt got=%0d exp=3", evt_s); end
    total++; if (evt !== 16'd5) begin bad++; $display("FAIL wide_evt got=%0d exp=5", evt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_r0();
    test_branch();
    test_simultaneous();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
